// File: rtl/qos_scheduler_if.sv
// rtl/qos_scheduler_if.sv - buffer-side and output-side signal bundle for qos_scheduler
interface qos_scheduler_if;
    logic        clk3sn;
    logic [11:0] cnt;
    logic [7:0]  buf_out_in;
    logic [3:0]  out_en_in;
    logic [3:0]  rd;
    logic [1:0]  pkt_out;
    logic [1:0]  pkt_src;
    logic        pkt_valid;
    logic [6:0]  served_cnt;
    logic [6:0]  idle_cnt;

    modport master (
        output clk3sn, cnt, buf_out_in, out_en_in,
        input  rd, pkt_out, pkt_src, pkt_valid, served_cnt, idle_cnt
    );

    modport slave (
        input  clk3sn, cnt, buf_out_in, out_en_in,
        output rd, pkt_out, pkt_src, pkt_valid, served_cnt, idle_cnt
    );
endinterface

// File: rtl/qos_scheduler.sv
// rtl/qos_scheduler.sv - weighted-occupancy read arbiter for four priority buffers, one read per clk3sn tick
// Optional starvation guard enabled by defining QOS_STARVE_GUARD_EN.
module qos_scheduler #(
    parameter logic [2:0] W0         = 3'd1,
    parameter logic [2:0] W1         = 3'd2,
    parameter logic [2:0] W2         = 3'd3,
    parameter logic [2:0] W3         = 3'd4,
    parameter int         RD_LAT     = 2,
    parameter logic [3:0] STARVE_LIM = 4'd8
) (
    input  logic           clk,
    input  logic           rst,
    qos_scheduler_if.slave bus
);

    typedef enum logic [1:0] {ST_ARM, ST_WAIT, ST_HOLD} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_prev;
    logic        w_tick;
    logic        w_sample;
    logic [3:0]  r_rd;
    logic [1:0]  r_sel;
    logic [2:0]  r_lat;
    logic [1:0]  r_pkt_out;
    logic [1:0]  r_pkt_src;
    logic        r_pkt_valid;
    logic [6:0]  r_served;
    logic [6:0]  r_idle;

    logic [5:0]  w_score [4];
    logic [5:0]  w_best;
    logic [1:0]  w_win;
    logic        w_win_valid;
    logic [3:0]  w_rd_nxt;

    // prev resets high so a clk3sn already high at reset release is not seen as an edge
    assign w_tick = ~r_prev & bus.clk3sn;

    always_comb begin
        w_score[0] = {3'b000, bus.cnt[2:0]}  * {3'b000, W0};
        w_score[1] = {3'b000, bus.cnt[5:3]}  * {3'b000, W1};
        w_score[2] = {3'b000, bus.cnt[8:6]}  * {3'b000, W2};
        w_score[3] = {3'b000, bus.cnt[11:9]} * {3'b000, W3};
    end

`ifdef QOS_STARVE_GUARD_EN
    logic [3:0] r_starve [4];

    always_comb begin
        w_best      = 6'd0;
        w_win       = 2'd0;
        w_win_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (w_score[i] != 6'd0 && w_score[i] >= w_best) begin
                w_best      = w_score[i];
                w_win       = 2'(i);
                w_win_valid = 1'b1;
            end
        end
        // descending scan so the lowest starving index is the last one written
        for (int i = 3; i >= 0; i--) begin
            if (r_starve[i] >= STARVE_LIM && bus.cnt[3*i +: 3] != 3'd0) begin
                w_win       = 2'(i);
                w_win_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) r_starve[i] <= 4'd0;
        end else if (r_state == ST_ARM && w_tick) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.cnt[3*i +: 3] == 3'd0 || r_rd[i])
                    r_starve[i] <= 4'd0;
                else if (r_starve[i] != 4'hf)
                    r_starve[i] <= r_starve[i] + 4'd1;
            end
        end
    end
`else
    always_comb begin
        w_best      = 6'd0;
        w_win       = 2'd0;
        w_win_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (w_score[i] != 6'd0 && w_score[i] >= w_best) begin
                w_best      = w_score[i];
                w_win       = 2'(i);
                w_win_valid = 1'b1;
            end
        end
    end
`endif

    assign w_rd_nxt = w_win_valid ? (4'b0001 << w_win) : 4'b0000;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_ARM;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sample    = 1'b0;
        case (r_state)
            ST_ARM: begin
                if (w_tick) w_state_nxt = (r_rd == 4'b0000) ? ST_HOLD : ST_WAIT;
            end
            ST_WAIT: begin
                if (r_lat == 3'(RD_LAT)) begin
                    w_sample    = 1'b1;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!bus.clk3sn) w_state_nxt = ST_ARM;
            end
            default: w_state_nxt = ST_ARM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev      <= 1'b1;
            r_rd        <= 4'b0000;
            r_sel       <= 2'd0;
            r_lat       <= 3'd0;
            r_pkt_out   <= 2'd0;
            r_pkt_src   <= 2'd0;
            r_pkt_valid <= 1'b0;
            r_served    <= 7'd0;
            r_idle      <= 7'd0;
        end else begin
            r_prev      <= bus.clk3sn;
            r_pkt_valid <= 1'b0;
            case (r_state)
                ST_ARM: begin
                    // rd tracks the winner until the tick, then stays frozen for the buffer to latch
                    if (!w_tick) begin
                        r_rd  <= w_rd_nxt;
                        r_sel <= w_win;
                    end else begin
                        r_lat <= 3'd1;
                        if (r_rd == 4'b0000) r_idle <= r_idle + 7'd1;
                    end
                end
                ST_WAIT: begin
                    r_lat <= r_lat + 3'd1;
                    if (w_sample) begin
                        if (bus.out_en_in[r_sel]) begin
                            r_pkt_out   <= bus.buf_out_in[2*r_sel +: 2];
                            r_pkt_src   <= r_sel;
                            r_pkt_valid <= 1'b1;
                            r_served    <= r_served + 7'd1;
                        end else begin
                            r_idle <= r_idle + 7'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.rd         = r_rd;
    assign bus.pkt_out    = r_pkt_out;
    assign bus.pkt_src    = r_pkt_src;
    assign bus.pkt_valid  = r_pkt_valid;
    assign bus.served_cnt = r_served;
    assign bus.idle_cnt   = r_idle;

endmodule
